// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: bundle of every bus-level signal of alu_share_arbiter.
//   slave  : arbiter view (inputs: requests, response ready, ALU results;
//            outputs: request ready, responses, ALU drive, busy, op_count)
//   master : environment view (requesters, response consumers, ALU instance)
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OP_W  = 3
);

  // requester 0 / 1 command channels
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OP_W-1:0]  req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OP_W-1:0]  req1_op;

  // requester 0 / 1 response slots
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;
  logic             rsp0_ovf;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;
  logic             rsp1_ovf;

  // shared combinational ALU
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OP_W-1:0]  alu_ctrl;
  logic             alu_enable;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_overflow;

  // status
  logic             busy;
  logic [7:0]       op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_ovf,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_ovf,
    input  rsp1_ready,
    output alu_a, alu_b, alu_ctrl, alu_enable,
    input  alu_result, alu_zero, alu_overflow,
    output busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_ovf,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_ovf,
    output rsp1_ready,
    input  alu_a, alu_b, alu_ctrl, alu_enable,
    output alu_result, alu_zero, alu_overflow,
    input  busy, op_count
  );

endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one ISSUE cycle driving the ALU, result captured
// into a per-requester response slot with its own valid/ready handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_share_arbiter_if.slave (request/response channels, ALU drive
//          and results, busy, op_count)
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OP_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic                       r_prio;
  logic                       r_owner;
  logic [WIDTH-1:0]           r_a;
  logic [WIDTH-1:0]           r_b;
  logic [OP_W-1:0]            r_op;

  logic [1:0]                 r_rsp_valid;
  logic [1:0][WIDTH-1:0]      r_rsp_result;
  logic [1:0]                 r_rsp_zero;
  logic [1:0]                 r_rsp_ovf;
  logic [CNT_W-1:0]           r_op_count;

  logic [1:0]                 w_elig;
  logic [1:0]                 w_grant;
  logic [1:0]                 w_rsp_fire;
  logic                       w_ovf_kept;

  // Eligibility looks only at the registered slot: a slot draining this
  // cycle still blocks its requester until the next cycle.
  assign w_elig[0] = bus.req0_valid && !r_rsp_valid[0];
  assign w_elig[1] = bus.req1_valid && !r_rsp_valid[1];

  assign w_rsp_fire[0] = r_rsp_valid[0] && bus.rsp0_ready;
  assign w_rsp_fire[1] = r_rsp_valid[1] && bus.rsp1_ready;

  // Overflow is only meaningful for the two arithmetic opcodes.
  assign w_ovf_kept = (r_op == OP_W'(0)) || (r_op == OP_W'(1));

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (!rst) begin
          if (w_elig[0] && (!w_elig[1] || !r_prio)) begin
            w_grant = 2'b01;
          end else if (w_elig[1]) begin
            w_grant = 2'b10;
          end
          if (w_grant != 2'b00) begin
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, command latch, response slots and op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_prio       <= 1'b0;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= '0;
      r_rsp_ovf    <= '0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant != 2'b00) begin
        r_owner <= w_grant[1];
        r_prio  <= !w_grant[1];
        r_a     <= w_grant[1] ? bus.req1_a  : bus.req0_a;
        r_b     <= w_grant[1] ? bus.req1_b  : bus.req0_b;
        r_op    <= w_grant[1] ? bus.req1_op : bus.req0_op;
      end

      for (int i = 0; i < 2; i++) begin
        if (w_rsp_fire[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end

      // The owner's slot was empty at grant and cannot fill meanwhile,
      // so this never collides with a drain of the same slot.
      if (r_state == ST_ISSUE) begin
        r_rsp_valid[r_owner]  <= 1'b1;
        r_rsp_result[r_owner] <= bus.alu_result;
        r_rsp_zero[r_owner]   <= bus.alu_zero;
        r_rsp_ovf[r_owner]    <= bus.alu_overflow && w_ovf_kept;
        r_op_count            <= r_op_count + CNT_W'(1);
      end
    end
  end

  // Ready is combinational and limited to the single winner in IDLE.
  assign bus.req0_ready  = w_grant[0];
  assign bus.req1_ready  = w_grant[1];

  assign bus.rsp0_valid  = r_rsp_valid[0];
  assign bus.rsp0_result = r_rsp_result[0];
  assign bus.rsp0_zero   = r_rsp_zero[0];
  assign bus.rsp0_ovf    = r_rsp_ovf[0];

  assign bus.rsp1_valid  = r_rsp_valid[1];
  assign bus.rsp1_result = r_rsp_result[1];
  assign bus.rsp1_zero   = r_rsp_zero[1];
  assign bus.rsp1_ovf    = r_rsp_ovf[1];

  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_ctrl    = r_op;
  assign bus.alu_enable  = (r_state == ST_ISSUE);

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.op_count    = r_op_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a small
// behavioural 4-bit ALU attached to the shared ALU port.
module tb_alu_share_arbiter;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  alu_share_arbiter_if #(.WIDTH(4), .OP_W(3)) u_if ();

  alu_share_arbiter #(.WIDTH(4), .OP_W(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: add/sub report carry/borrow; logic ops deliberately raise overflow
  // so that masking in the arbiter is observable.
  always_comb begin
    logic [4:0] t;
    t = 5'd0;
    case (u_if.alu_ctrl)
      3'd0:    t = {1'b0, u_if.alu_a} + {1'b0, u_if.alu_b};
      3'd1:    t = {1'b0, u_if.alu_a} - {1'b0, u_if.alu_b};
      3'd2:    t = {1'b1, u_if.alu_a & u_if.alu_b};
      3'd3:    t = {1'b1, u_if.alu_a | u_if.alu_b};
      default: t = {1'b1, u_if.alu_a ^ u_if.alu_b};
    endcase
    u_if.alu_result   = t[3:0];
    u_if.alu_overflow = t[4];
    u_if.alu_zero     = (t[3:0] == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from a single requester: wait for grant,
  // check the ISSUE cycle, check the response, let the slot drain.
  task automatic do_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] er,
                       input logic ez, input logic eo, input string tag);
    int waited;
    waited = 0;
    if (!id) begin
      u_if.req0_a = a; u_if.req0_b = b; u_if.req0_op = op; u_if.req0_valid = 1'b1;
    end else begin
      u_if.req1_a = a; u_if.req1_b = b; u_if.req1_op = op; u_if.req1_valid = 1'b1;
    end
    #1;
    while (!(id ? u_if.req1_ready : u_if.req0_ready) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    chk({tag, "_grant"}, 32'(id ? u_if.req1_ready : u_if.req0_ready), 32'd1);
    @(negedge clk);
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;
    #1;
    chk({tag, "_busy"},  32'(u_if.busy),       32'd1);
    chk({tag, "_en"},    32'(u_if.alu_enable), 32'd1);
    chk({tag, "_alu_a"}, 32'(u_if.alu_a),      32'(a));
    chk({tag, "_alu_b"}, 32'(u_if.alu_b),      32'(b));
    chk({tag, "_ctrl"},  32'(u_if.alu_ctrl),   32'(op));
    @(negedge clk); #1;
    chk({tag, "_rvalid"}, 32'(id ? u_if.rsp1_valid  : u_if.rsp0_valid),  32'd1);
    chk({tag, "_result"}, 32'(id ? u_if.rsp1_result : u_if.rsp0_result), 32'(er));
    chk({tag, "_zero"},   32'(id ? u_if.rsp1_zero   : u_if.rsp0_zero),   32'(ez));
    chk({tag, "_ovf"},    32'(id ? u_if.rsp1_ovf    : u_if.rsp0_ovf),    32'(eo));
    @(negedge clk); #1;
    chk({tag, "_drain"},  32'(id ? u_if.rsp1_valid  : u_if.rsp0_valid),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_r0;
    logic [7:0]  exp_r1;
    logic [7:0]  exp_v0;
    logic [7:0]  exp_v1;
    logic [10:0] bp_r1;
    logic [3:0]  wa;
    logic [4:0]  sum;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    u_if.req0_valid = 1'b0; u_if.req0_a = 4'd0; u_if.req0_b = 4'd0; u_if.req0_op = 3'd0;
    u_if.req1_valid = 1'b0; u_if.req1_a = 4'd0; u_if.req1_b = 4'd0; u_if.req1_op = 3'd0;
    u_if.rsp0_ready = 1'b1;
    u_if.rsp1_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0",   32'(u_if.req0_ready),  32'd0);
    chk("rst_ready1",   32'(u_if.req1_ready),  32'd0);
    chk("rst_rvalid0",  32'(u_if.rsp0_valid),  32'd0);
    chk("rst_rvalid1",  32'(u_if.rsp1_valid),  32'd0);
    chk("rst_result0",  32'(u_if.rsp0_result), 32'd0);
    chk("rst_busy",     32'(u_if.busy),        32'd0);
    chk("rst_en",       32'(u_if.alu_enable),  32'd0);
    chk("rst_alu_a",    32'(u_if.alu_a),       32'd0);
    chk("rst_opcnt",    32'(u_if.op_count),    32'd0);

    // Basic add: 3 + 2 = 5, granted in the first cycle out of reset
    rst = 1'b0;
    u_if.req0_a = 4'd3; u_if.req0_b = 4'd2; u_if.req0_op = 3'd0; u_if.req0_valid = 1'b1;
    #1;
    chk("add_first_ready", 32'(u_if.req0_ready), 32'd1);
    do_op(1'b0, 4'd3, 4'd2, 3'd0, 4'd5, 1'b0, 1'b0, "add");
    chk("add_opcnt", 32'(u_if.op_count), 32'd1);

    // Overflow on add, then masked overflow on AND
    do_op(1'b1, 4'hF, 4'h1, 3'd0, 4'h0, 1'b1, 1'b1, "ovf_add");
    do_op(1'b1, 4'hF, 4'h0, 3'd2, 4'h0, 1'b1, 1'b0, "ovf_mask");
    chk("ovf_opcnt", 32'(u_if.op_count), 32'd3);

    // Contention from reset: strict alternation 0,1,0,1 every 2 cycles
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    u_if.req0_a = 4'd1; u_if.req0_b = 4'd1; u_if.req0_op = 3'd0; u_if.req0_valid = 1'b1;
    u_if.req1_a = 4'd2; u_if.req1_b = 4'd5; u_if.req1_op = 3'd0; u_if.req1_valid = 1'b1;
    exp_r0 = 8'b0001_0001;
    exp_r1 = 8'b0100_0100;
    exp_v0 = 8'b0100_0100;
    exp_v1 = 8'b0001_0000;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("cont_r0_c%0d", c), 32'(u_if.req0_ready), 32'(exp_r0[c]));
      chk($sformatf("cont_r1_c%0d", c), 32'(u_if.req1_ready), 32'(exp_r1[c]));
      chk($sformatf("cont_both_c%0d", c), 32'(u_if.req0_ready && u_if.req1_ready), 32'd0);
      chk($sformatf("cont_v0_c%0d", c), 32'(u_if.rsp0_valid), 32'(exp_v0[c]));
      chk($sformatf("cont_v1_c%0d", c), 32'(u_if.rsp1_valid), 32'(exp_v1[c]));
      if (c == 2) chk("cont_res0", 32'(u_if.rsp0_result), 32'd2);
      if (c == 4) chk("cont_res1", 32'(u_if.rsp1_result), 32'd7);
    end
    chk("cont_opcnt", 32'(u_if.op_count), 32'd3);
    u_if.req0_valid = 1'b0;
    u_if.req1_valid = 1'b0;

    // Backpressure: slot 0 stalls, req1 alone repeats every 3 cycles
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    u_if.rsp0_ready = 1'b0;
    u_if.req0_a = 4'd4; u_if.req0_b = 4'd4; u_if.req0_op = 3'd0; u_if.req0_valid = 1'b1;
    u_if.req1_a = 4'd1; u_if.req1_b = 4'd1; u_if.req1_op = 3'd0; u_if.req1_valid = 1'b1;
    bp_r1 = 11'b001_0010_0100;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) begin
        u_if.req0_a = 4'd6; u_if.req0_b = 4'd3;
      end
      if (c == 10) begin
        u_if.rsp0_ready = 1'b1;
        u_if.req1_valid = 1'b0;
      end
      #1;
      if (c == 0) chk("bp_r0_first", 32'(u_if.req0_ready), 32'd1);
      else chk($sformatf("bp_r0_c%0d", c), 32'(u_if.req0_ready), 32'd0);
      if (c >= 2) begin
        chk($sformatf("bp_r1_c%0d", c), 32'(u_if.req1_ready), 32'(bp_r1[c]));
        chk($sformatf("bp_v0_c%0d", c), 32'(u_if.rsp0_valid), 32'd1);
        chk($sformatf("bp_res0_c%0d", c), 32'(u_if.rsp0_result), 32'd8);
      end
      if (c == 4) chk("bp_res1", 32'(u_if.rsp1_result), 32'd2);
    end
    @(negedge clk); #1;
    chk("bp_release_grant", 32'(u_if.req0_ready), 32'd1);
    @(negedge clk);
    u_if.req0_valid = 1'b0;
    #1;
    chk("bp_release_alu_a", 32'(u_if.alu_a), 32'd6);
    @(negedge clk); #1;
    chk("bp_release_valid", 32'(u_if.rsp0_valid), 32'd1);
    chk("bp_release_res",   32'(u_if.rsp0_result), 32'd9);
    @(negedge clk); #1;

    // Mid-op reset discards the in-flight op
    u_if.req0_a = 4'd5; u_if.req0_b = 4'd5; u_if.req0_op = 3'd0; u_if.req0_valid = 1'b1;
    #1;
    chk("mid_grant", 32'(u_if.req0_ready), 32'd1);
    @(negedge clk);
    u_if.req0_valid = 1'b0;
    #1;
    chk("mid_busy", 32'(u_if.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_v0",    32'(u_if.rsp0_valid),  32'd0);
    chk("mid_v1",    32'(u_if.rsp1_valid),  32'd0);
    chk("mid_res0",  32'(u_if.rsp0_result), 32'd0);
    chk("mid_opcnt", 32'(u_if.op_count),    32'd0);
    chk("mid_busy0", 32'(u_if.busy),        32'd0);
    chk("mid_en",    32'(u_if.alu_enable),  32'd0);
    chk("mid_alu_a", 32'(u_if.alu_a),       32'd0);
    rst = 1'b0;
    do_op(1'b0, 4'd1, 4'd1, 3'd0, 4'd2, 1'b0, 1'b0, "mid_fresh");
    chk("mid_fresh_opcnt", 32'(u_if.op_count), 32'd1);

    // Counter wrap: 255 more ops make 256, then one more
    for (int k = 0; k < 255; k++) begin
      wa  = 4'(k);
      sum = {1'b0, wa} + 5'd1;
      do_op(k[0], wa, 4'd1, 3'd0, sum[3:0], (sum[3:0] == 4'd0), sum[4], "wrap");
    end
    chk("wrap_zero", 32'(u_if.op_count), 32'd0);
    do_op(1'b0, 4'd7, 4'd8, 3'd0, 4'hF, 1'b0, 1'b0, "wrap_257");
    chk("wrap_one", 32'(u_if.op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
